// File: rtl/perf_pkg.sv
// Shared perf-counter definitions: counter width and the fixed source index order.
package perf_pkg;
    localparam int PERF_CTR_BITS = 44;

    typedef enum logic [2:0] {
        PERF_SRC_TEX,
        PERF_SRC_RASTER,
        PERF_SRC_ROP,
        PERF_SRC_IMADD,
        PERF_SRC_WCTL,
        PERF_SRC_COUNT
    } perf_src_e;

    typedef logic [PERF_CTR_BITS-1:0] perf_ctr_t;
endpackage

// File: rtl/perf_stall_counter_unit_if.sv
// Request-side sample bus and counter outputs of the stall counter unit.
interface perf_stall_counter_unit_if
    import perf_pkg::*;
#(
    parameter int NUM_SRCS  = int'(PERF_SRC_COUNT),
    parameter int NUM_LANES = 4,
    parameter int CTR_BITS  = PERF_CTR_BITS
);
    logic [NUM_SRCS*NUM_LANES-1:0] req_valid;
    logic [NUM_SRCS*NUM_LANES-1:0] req_ready;
    logic                          perf_en;
    logic                          clear;
    logic                          freeze;
    logic [NUM_SRCS*CTR_BITS-1:0]  stall_ctr;
    logic [NUM_SRCS-1:0]           ctr_ovf;

    modport master (
        output req_valid, req_ready, perf_en, clear, freeze,
        input  stall_ctr, ctr_ovf
    );

    modport slave (
        input  req_valid, req_ready, perf_en, clear, freeze,
        output stall_ctr, ctr_ovf
    );
endinterface

// File: rtl/perf_stall_ctr.sv
// One source's stall counter: registered lane mask, reduction to an increment,
// wrapping accumulator with a sticky overflow flag.
module perf_stall_ctr #(
    parameter int NUM_LANES   = 4,
    parameter int CTR_BITS    = 44,
    parameter int COUNT_LANES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 freeze,
    input  logic [NUM_LANES-1:0] stall_in,
    output logic [CTR_BITS-1:0]  ctr,
    output logic                 ovf
);
    localparam int IW = $clog2(NUM_LANES + 1);

    logic [NUM_LANES-1:0] r_mask;
    logic [CTR_BITS-1:0]  r_ctr;
    logic                 r_ovf;
    logic [IW-1:0]        w_inc;
    logic [CTR_BITS:0]    w_sum;

    always_comb begin
        w_inc = (COUNT_LANES != 0) ? IW'($countones(r_mask)) : IW'(|r_mask);
        w_sum = {1'b0, r_ctr} + (CTR_BITS+1)'(w_inc);
    end

    // clear also flushes the mask so the sample already in flight is discarded
    always_ff @(posedge clk) begin
        if (reset || clear) r_mask <= '0;
        else                r_mask <= stall_in;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_ctr <= '0;
            r_ovf <= 1'b0;
        end else if (!freeze) begin
            r_ctr <= w_sum[CTR_BITS-1:0];
            r_ovf <= r_ovf | w_sum[CTR_BITS];
        end
    end

    assign ctr = r_ctr;
    assign ovf = r_ovf;
endmodule

// File: rtl/perf_stall_counter_unit.sv
// Per-cluster stall counters for tex/raster/rop/imadd/wctl: slices lanes per
// source, applies perf_en, and packs the per-source counters onto the bus.
module perf_stall_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_SRCS    = int'(PERF_SRC_COUNT),
    parameter int NUM_LANES   = 4,
    parameter int CTR_BITS    = PERF_CTR_BITS,
    parameter int COUNT_LANES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    perf_stall_counter_unit_if.slave bus
);
    logic [NUM_SRCS-1:0][NUM_LANES-1:0] w_stall;
    logic [NUM_SRCS-1:0][CTR_BITS-1:0]  w_ctr;
    logic [NUM_SRCS-1:0]                w_ovf;

    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
        assign w_stall[s] = bus.req_valid[s*NUM_LANES +: NUM_LANES]
                          & ~bus.req_ready[s*NUM_LANES +: NUM_LANES]
                          & {NUM_LANES{bus.perf_en}};

        perf_stall_ctr #(
            .NUM_LANES   (NUM_LANES),
            .CTR_BITS    (CTR_BITS),
            .COUNT_LANES (COUNT_LANES)
        ) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .clear    (bus.clear),
            .freeze   (bus.freeze),
            .stall_in (w_stall[s]),
            .ctr      (w_ctr[s]),
            .ovf      (w_ovf[s])
        );
    end

    assign bus.stall_ctr = w_ctr;
    assign bus.ctr_ovf   = w_ovf;
endmodule

// File: tb/tb_perf_stall_counter_unit.sv
// Bench for perf_stall_counter_unit: a full-width any-lane instance and a
// narrow lane-counting instance driven by the same stimulus.
module tb_perf_stall_counter_unit;
    localparam int NS = 5;
    localparam int NL = 4;
    localparam int W0 = 44;
    localparam int W1 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    perf_stall_counter_unit_if #(.NUM_SRCS(NS), .NUM_LANES(NL), .CTR_BITS(W0)) if0 ();
    perf_stall_counter_unit_if #(.NUM_SRCS(NS), .NUM_LANES(NL), .CTR_BITS(W1)) if1 ();

    assign if1.req_valid = if0.req_valid;
    assign if1.req_ready = if0.req_ready;
    assign if1.perf_en   = if0.perf_en;
    assign if1.clear     = if0.clear;
    assign if1.freeze    = if0.freeze;

    perf_stall_counter_unit #(.NUM_SRCS(NS), .NUM_LANES(NL), .CTR_BITS(W0), .COUNT_LANES(0))
        dut0 (.clk(clk), .reset(rst), .bus(if0));
    perf_stall_counter_unit #(.NUM_SRCS(NS), .NUM_LANES(NL), .CTR_BITS(W1), .COUNT_LANES(1))
        dut1 (.clk(clk), .reset(rst), .bus(if1));

    // Reference: a sample from cycle k lands at the end of cycle k+1 unless
    // reset/clear occurs in cycle k or k+1, or freeze is high in cycle k+1.
    longint unsigned m0[NS], m1[NS];
    longint unsigned p0[NS], p1[NS];
    logic [NS-1:0]   mo0 = '0, mo1 = '0;

    initial for (int s = 0; s < NS; s++) begin
        m0[s] = 0; m1[s] = 0; p0[s] = 0; p1[s] = 0;
    end

    always @(posedge clk) begin
        logic [NL-1:0] st;
        int            c;
        for (int s = 0; s < NS; s++) begin
            if (rst || if0.clear) begin
                m0[s] = 0; m1[s] = 0; mo0[s] = 1'b0; mo1[s] = 1'b0;
            end else if (!if0.freeze) begin
                m0[s] = m0[s] + p0[s];
                m1[s] = m1[s] + p1[s];
                if (m0[s] >= (64'd1 << W0)) begin m0[s] = m0[s] - (64'd1 << W0); mo0[s] = 1'b1; end
                if (m1[s] >= (64'd1 << W1)) begin m1[s] = m1[s] - (64'd1 << W1); mo1[s] = 1'b1; end
            end
            st = if0.req_valid[s*NL +: NL] & ~if0.req_ready[s*NL +: NL];
            c  = if0.perf_en ? $countones(st) : 0;
            if (rst || if0.clear) c = 0;
            p0[s] = (c != 0) ? 1 : 0;
            p1[s] = longint'(c);
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [NS*NL-1:0] v, input logic [NS*NL-1:0] r,
                       input logic en, input logic cl, input logic fz);
        if0.req_valid = v;
        if0.req_ready = r;
        if0.perf_en   = en;
        if0.clear     = cl;
        if0.freeze    = fz;
    endtask

    typedef struct {
        logic [NS*NL-1:0]   v;
        logic [NS*NL-1:0]   r;
        logic               en;
        logic               fz;
        int                 n;
        logic [NS-1:0][7:0] e0;
        logic [NS-1:0][7:0] e1;
        logic [NS-1:0]      o1;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [NS*W0-1:0] x0;
        logic [NS*W1-1:0] x1;

        // byte order in e0/e1 is wctl..tex
        tbl[0] = '{20'h00005, 20'h00000, 1'b1, 1'b0, 10, 40'h00_00_00_00_0A, 40'h00_00_00_00_04, 5'b00001};
        tbl[1] = '{20'h00700, 20'h00000, 1'b1, 1'b0, 4,  40'h00_00_04_00_00, 40'h00_00_0C_00_00, 5'b00000};
        tbl[2] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0, 5,  40'h00_00_00_00_00, 40'h00_00_00_00_00, 5'b00000};
        tbl[3] = '{20'hFFFFF, 20'h00000, 1'b0, 1'b0, 5,  40'h00_00_00_00_00, 40'h00_00_00_00_00, 5'b00000};
        tbl[4] = '{20'hF0F31, 20'h30101, 1'b1, 1'b0, 3,  40'h03_00_03_03_00, 40'h06_00_09_06_00, 5'b00000};
        tbl[5] = '{20'hFFFFF, 20'h00000, 1'b1, 1'b1, 4,  40'h01_01_01_01_01, 40'h04_04_04_04_04, 5'b00000};
        tbl[6] = '{20'hFFFFF, 20'h00000, 1'b1, 1'b0, 4,  40'h04_04_04_04_04, 40'h00_00_00_00_00, 5'b11111};

        // reset held with every lane stalled
        drv('1, '0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_ctr", if0.stall_ctr, '0);
            chk("rst_ovf", if0.ctr_ovf, '0);
        end
        rst = 1'b0;
        cyc();
        chk("rel1_tex", if0.stall_ctr[0 +: W0], 0);
        cyc();
        chk("rel2_tex", if0.stall_ctr[0 +: W0], 1);
        chk("rel2_lanes_tex", if1.stall_ctr[0 +: W1], 4);

        // table: clear, apply n cycles, drain, compare
        foreach (tbl[k]) begin
            drv('0, '0, 1'b1, 1'b1, 1'b0);
            cyc();
            drv(tbl[k].v, tbl[k].r, tbl[k].en, 1'b0, tbl[k].fz);
            for (int i = 0; i < tbl[k].n; i++) cyc();
            drv('0, '0, 1'b1, 1'b0, 1'b0);
            cyc();
            cyc();
            for (int s = 0; s < NS; s++) begin
                x0[s*W0 +: W0] = W0'(tbl[k].e0[s]);
                x1[s*W1 +: W1] = W1'(tbl[k].e1[s]);
            end
            chk($sformatf("vec%0d_ctr0", k), if0.stall_ctr, x0);
            chk($sformatf("vec%0d_ovf0", k), if0.ctr_ovf, '0);
            chk($sformatf("vec%0d_ctr1", k), if1.stall_ctr, x1);
            chk($sformatf("vec%0d_ovf1", k), if1.ctr_ovf, tbl[k].o1);
        end

        // raster stall for 20 cycles, freeze over 5 of them
        drv('0, '0, 1'b1, 1'b1, 1'b0);
        cyc();
        for (int i = 1; i <= 20; i++) begin
            drv(20'h00010, '0, 1'b1, 1'b0, (i >= 8 && i <= 12));
            cyc();
        end
        drv('0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("freeze_raster", if0.stall_ctr[1*W0 +: W0], 15);

        // narrow wctl counter up to all-ones, then one more lane wraps it
        drv('0, '0, 1'b1, 1'b1, 1'b0);
        cyc();
        drv(20'hF0000, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        drv(20'h70000, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        drv('0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("wrap_max", if1.stall_ctr[4*W1 +: W1], 15);
        chk("wrap_max_ovf", if1.ctr_ovf, '0);
        drv(20'h10000, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        drv('0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("wrap_zero", if1.stall_ctr[4*W1 +: W1], 0);
        chk("wrap_ovf", if1.ctr_ovf, 5'b10000);
        chk("wrap_wide", if0.stall_ctr[4*W0 +: W0], 5);
        drv('0, '0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("wrap_clr_ovf", if1.ctr_ovf, '0);

        // clear in the middle of a continuous imadd stall
        drv(20'h0F000, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        drv(20'h0F000, '0, 1'b1, 1'b1, 1'b0);
        cyc();
        chk("clr_t1", if0.stall_ctr[3*W0 +: W0], 0);
        drv(20'h0F000, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("clr_t2", if0.stall_ctr[3*W0 +: W0], 0);
        cyc();
        chk("clr_t3", if0.stall_ctr[3*W0 +: W0], 1);
        cyc();
        drv(20'h0F000, '0, 1'b1, 1'b1, 1'b1);
        cyc();
        chk("clr_frz", if0.stall_ctr[3*W0 +: W0], 0);

        // randomized traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            drv(NS*NL'($urandom), NS*NL'($urandom), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0));
            rst = ($urandom_range(0, 199) == 0);
            cyc();
            for (int s = 0; s < NS; s++) begin
                x0[s*W0 +: W0] = W0'(m0[s]);
                x1[s*W1 +: W1] = W1'(m1[s]);
            end
            chk("rnd_ctr0", if0.stall_ctr, x0);
            chk("rnd_ovf0", if0.ctr_ovf, mo0);
            chk("rnd_ctr1", if1.stall_ctr, x1);
            chk("rnd_ovf1", if1.ctr_ovf, mo1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
